// File: rtl/saw_pkg.sv
// Shared sample-stream types for the saw generator and its PWM DAC consumer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package saw_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/pwm_frame_timer.sv
// Prescaled tick and frame counter for the PWM DAC; emits tick, frame boundary and next count.
// Latency: outputs are combinational from the pre/cnt registers.
// Backpressure: none; ena low freezes both counters in place.
module pwm_frame_timer
  import saw_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic             tick,
  output logic             boundary,
  output logic [WIDTH-1:0] cnt_next
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] cnt;

  assign tick     = ena && (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);
  // Downstream compares against the count that will be live after this edge.
  assign cnt_next = tick ? cnt + WIDTH'(1) : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (ena) begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/saw_pwm_dac.sv
// Sawtooth sample consumer: one-deep holding buffer feeding a per-frame PWM duty register.
// Latency: accepted sample becomes duty at the next frame boundary; pwm_out is registered.
// Backpressure: sample_ready is low while the holding buffer is full or ena is low.
module saw_pwm_dac
  import saw_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             underrun,
  input  logic             underrun_clr
);

  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] cnt_next;

  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] duty_next;
  logic [WIDTH-1:0] hold;
  logic             hold_full;

  logic             accept;
  logic             frame_edge;
  logic             load;
  logic             miss;

  pwm_frame_timer #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .tick     (tick),
    .boundary (boundary),
    .cnt_next (cnt_next)
  );

  assign sample_ready = ena & ~hold_full;
  assign accept       = sample_valid & sample_ready;

  // A frame edge is the wrapping tick; an accept landing on it is too late for it.
  assign frame_edge = tick & boundary;
  assign load       = frame_edge & hold_full;
  assign miss       = frame_edge & ~hold_full;

  // The new duty must already govern the first tick of its own frame.
  assign duty_next = load ? hold : duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty        <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (accept) begin
        hold <= sample_in;
      end

      if (load) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end

      duty        <= duty_next;
      pwm_out     <= ena & (cnt_next < duty_next);
      frame_start <= frame_edge;

      // Set beats clear; a frozen tile keeps its flag untouched.
      if (miss) begin
        underrun <= 1'b1;
      end else if (ena && underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
